// File: rtl/wa_window_buffer.sv
// wa_window_buffer: word-addressable line buffer with masked writes and 2-cycle unaligned window reads
// Ports:
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   writeEn    write strobe; writeMask selects words, writeAddr selects line, dataIn carries the line
//   readEn     read request for the window at line readAddr, word readOffset
//   dataOut    WinWords-word window, word 0 in the LSBs
//   readValid  one-cycle pulse per request, two cycles after it
//   readErr    request was out of range; dataOut is zero in that case
module wa_window_buffer #(
    parameter int WordWidth = 8,
    parameter int Width     = 5,
    parameter int Depth     = 5,
    parameter int WinWords  = 3,
    parameter int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    parameter int OffWidth  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          writeEn,
    input  logic [Width-1:0]              writeMask,
    input  logic [AddrWidth-1:0]          writeAddr,
    input  logic [Width*WordWidth-1:0]    dataIn,
    input  logic                          readEn,
    input  logic [AddrWidth-1:0]          readAddr,
    input  logic [OffWidth-1:0]           readOffset,
    output logic [WinWords*WordWidth-1:0] dataOut,
    output logic                          readValid,
    output logic                          readErr
);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    logic [WordWidth-1:0]          r_mem [Depth][Width];
    logic [Width*WordWidth-1:0]    r_line_a, r_line_b;
    logic [OffWidth-1:0]           r_off;
    logic                          r_err, r_v1;
    logic                          w_wr_ok, w_rd_ok, w_err;
    logic [AddrWidth-1:0]          w_ra, w_rb;
    logic [Width*WordWidth-1:0]    w_line_a, w_line_b;
    logic [2*Width*WordWidth-1:0]  w_shift;

    assign w_wr_ok = 32'(writeAddr) < 32'(Depth);
    assign w_rd_ok = 32'(readAddr) < 32'(Depth);
    assign w_err   = !w_rd_ok || (32'(readOffset) >= 32'(Width));
    // Illegal addresses are steered to line 0 so the array is never indexed out of range
    assign w_ra    = w_rd_ok ? readAddr : '0;
    assign w_rb    = (w_ra == LastAddr) ? '0 : w_ra + 1'b1;

    always_comb begin
        w_line_a = '0;
        w_line_b = '0;
        for (int i = 0; i < Width; i++) begin
            w_line_a[i*WordWidth +: WordWidth] = r_mem[w_ra][i];
            w_line_b[i*WordWidth +: WordWidth] = r_mem[w_rb][i];
        end
    end

    // Window = {lineB,lineA} shifted down by the word offset
    assign w_shift = {r_line_b, r_line_a} >> (32'(r_off) * WordWidth);

    // Memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (writeEn && w_wr_ok)
            for (int i = 0; i < Width; i++)
                if (writeMask[i]) r_mem[writeAddr][i] <= dataIn[i*WordWidth +: WordWidth];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_line_a  <= '0;
            r_line_b  <= '0;
            r_off     <= '0;
            r_err     <= 1'b0;
            r_v1      <= 1'b0;
            dataOut   <= '0;
            readValid <= 1'b0;
            readErr   <= 1'b0;
        end else begin
            r_line_a  <= w_line_a;
            r_line_b  <= w_line_b;
            r_off     <= readOffset;
            r_err     <= w_err;
            r_v1      <= readEn;
            readValid <= r_v1;
            readErr   <= r_v1 && r_err;
            if (r_v1) dataOut <= r_err ? '0 : w_shift[WinWords*WordWidth-1:0];
        end
    end
endmodule

// File: tb/tb_wa_window_buffer.sv
// tb_wa_window_buffer: randomized and directed check of wa_window_buffer against a word-level model
module tb_wa_window_buffer;
    localparam int WW = 8, W = 5, D = 5, WN = 3;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              writeEn = 1'b0;
    logic [W-1:0]      writeMask = '0;
    logic [2:0]        writeAddr = '0;
    logic [W*WW-1:0]   dataIn = '0;
    logic              readEn = 1'b0;
    logic [2:0]        readAddr = '0;
    logic [2:0]        readOffset = '0;
    logic [WN*WW-1:0]  dataOut;
    logic              readValid, readErr;

    int compared = 0, mismatched = 0;

    logic [7:0]  m [D][W];
    logic        p_v = 1'b0, p_e = 1'b0, o_v = 1'b0, o_e = 1'b0;
    logic [23:0] p_d = '0, o_d = '0;

    always #5 clk = ~clk;

    wa_window_buffer dut (
        .clk(clk), .nrst(nrst), .writeEn(writeEn), .writeMask(writeMask),
        .writeAddr(writeAddr), .dataIn(dataIn), .readEn(readEn), .readAddr(readAddr),
        .readOffset(readOffset), .dataOut(dataOut), .readValid(readValid), .readErr(readErr)
    );

    function automatic logic [23:0] win(int a, int o);
        logic [23:0] r = '0;
        for (int i = 0; i < WN; i++) r[i*8 +: 8] = m[(a + (o + i) / W) % D][(o + i) % W];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [4:0] mk, input logic [2:0] wa,
                       input logic [39:0] di, input logic re, input logic [2:0] ra,
                       input logic [2:0] ro);
        writeEn = we; writeMask = mk; writeAddr = wa; dataIn = di;
        readEn = re; readAddr = ra; readOffset = ro;
        @(posedge clk);
        if (!nrst) begin
            o_v = 0; o_e = 0; o_d = '0; p_v = 0;
        end else begin
            o_v = p_v;
            o_e = p_v && p_e;
            if (p_v) o_d = p_d;
            p_v = re;
            p_e = (ra >= D) || (ro >= W);
            p_d = p_e ? 24'h0 : win(ra, ro);
        end
        if (we && wa < D)
            for (int i = 0; i < W; i++) if (mk[i]) m[wa][i] = di[i*8 +: 8];
        #1;
        chk("valid", 64'(readValid), 64'(o_v));
        chk("err", 64'(readErr), 64'(o_e));
        chk("data", 64'(dataOut), 64'(o_d));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(readValid), 0);
        chk("rst_err", 64'(readErr), 0);
        chk("rst_data", 64'(dataOut), 0);
        nrst = 1'b1;
        for (int l = 0; l < D; l++) cyc(1, 5'h1F, 3'(l), {$urandom, $urandom}, 0, 0, 0);
        // aligned read
        cyc(1, 5'h1F, 0, 40'h0504030201, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle();
        chk("t1", 64'(dataOut), 64'h030201);
        // window crossing into next line
        cyc(1, 5'h1F, 1, 40'h0A09080706, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 3);
        idle();
        chk("t2", 64'(dataOut), 64'h060504);
        // wrap from last line to line 0
        cyc(1, 5'h1F, 4, 40'h1514131211, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4, 4);
        idle();
        chk("t3", 64'(dataOut), 64'h020115);
        // masked write colliding with a read
        cyc(1, 5'b00100, 0, 40'hFFFFFFFFFF, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("t4_old", 64'(dataOut), 64'h030201);
        idle();
        chk("t4_new", 64'(dataOut), 64'hFF0201);
        // illegal requests and dropped write
        cyc(0, 0, 0, 0, 1, 5, 0);
        cyc(0, 0, 0, 0, 1, 0, 5);
        cyc(1, 5'h1F, 7, 40'h123456789A, 0, 0, 0);
        chk("t5_err", 64'(readErr), 1);
        idle();
        for (int l = 0; l < D; l++) cyc(0, 0, 0, 0, 1, 3'(l), 0);
        idle(); idle();
        // reset with reads in flight
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 3'(k), 3'(k));
        nrst = 1'b0;
        #1;
        o_v = 0; o_e = 0; o_d = '0; p_v = 0;
        chk("t6_valid", 64'(readValid), 0);
        chk("t6_data", 64'(dataOut), 0);
        idle(); idle();
        nrst = 1'b1;
        cyc(0, 0, 0, 0, 1, 1, 2);
        chk("t6_gap", 64'(readValid), 0);
        idle();
        chk("t6_read", 64'(dataOut), 64'(win(1, 2)));
        idle();
        // random traffic
        for (int n = 0; n < 400; n++)
            cyc(1'($urandom), 5'($urandom), 3'($urandom_range(0, 5)), {$urandom, $urandom},
                1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)));
        idle(); idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
